// File: rtl/pc8001m_pkg.sv
// Shared types and defaults for the PC-8001 core glue: loader FSM states, ROM image
// index and default sizing.
package pc8001m_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StWrite,
      StHold
   } load_state_e;

   localparam logic [7:0]  ROM_INDEX_BIND88   = 8'd1;
   localparam int unsigned ROM_AW_DEFAULT     = 15;
   localparam int unsigned RST_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/reset_stretch.sv
// Loadable down-counter used to stretch a reset pulse; last_o flags the final count so the
// owner can release on the same edge the counter reaches zero.
module reset_stretch #(
   parameter int unsigned CYCLES = 1024,
   parameter int unsigned CW     = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic busy_o,
   output logic last_o
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = CW'(CYCLES);
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= CW'(CYCLES);
      end else begin
         count_q <= count_d;
      end
   end

   assign busy_o = (count_q != '0);
   assign last_o = (count_q == CW'(1));

endmodule

// File: rtl/rom_load_ctrl.sv
// Moves the HPS ROM download into the core's ROM write port one byte at a time, throttling
// the HPS with ioctl_wait and holding the CPU in reset during and after the load.
module rom_load_ctrl
   import pc8001m_pkg::*;
#(
   parameter int unsigned ROM_AW     = ROM_AW_DEFAULT,
   parameter logic [7:0]  LOAD_INDEX = ROM_INDEX_BIND88,
   parameter int unsigned RST_CYCLES = RST_CYCLES_DEFAULT
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic              ioctl_download_i,
   input  logic [7:0]        ioctl_index_i,
   input  logic              ioctl_wr_i,
   input  logic [24:0]       ioctl_addr_i,
   input  logic [7:0]        ioctl_dout_i,
   output logic              ioctl_wait_o,
   output logic              rom_req_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   output logic [7:0]        rom_data_o,
   input  logic              rom_ack_i,
   input  logic              reset_req_i,
   output logic              cpu_reset_o,
   output logic              rom_loaded_o,
   output logic              load_err_o,
   output logic [ROM_AW:0]   byte_count_o
);

   localparam logic [24:0]     ROM_SIZE  = 25'(1) << ROM_AW;
   localparam logic [ROM_AW:0] COUNT_MAX = {1'b1, {ROM_AW{1'b0}}};
   localparam logic [ROM_AW:0] COUNT_ONE = {{ROM_AW{1'b0}}, 1'b1};

   load_state_e       state_q, state_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              ioctl_wait_q, ioctl_wait_d;
   logic              rom_req_q, rom_req_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        rom_data_q, rom_data_d;
   logic              rom_loaded_q, rom_loaded_d;
   logic              load_err_q, load_err_d;
   logic [ROM_AW:0]   byte_count_q, byte_count_d;

   logic hold_load, hold_en, hold_busy, hold_last;
   logic dl_match, in_range;

   assign dl_match = ioctl_download_i && (ioctl_index_i == LOAD_INDEX);
   assign in_range = (ioctl_addr_i < ROM_SIZE);

   reset_stretch #(
      .CYCLES (RST_CYCLES),
      .CW     (16)
   ) u_hold (
      .clk_i  (clk_sys_i),
      .rst_i  (reset_i),
      .load_i (hold_load),
      .en_i   (hold_en),
      .busy_o (hold_busy),
      .last_o (hold_last)
   );

   always_comb begin
      state_d      = state_q;
      cpu_reset_d  = cpu_reset_q;
      ioctl_wait_d = ioctl_wait_q;
      rom_req_d    = rom_req_q;
      rom_addr_d   = rom_addr_q;
      rom_data_d   = rom_data_q;
      rom_loaded_d = rom_loaded_q;
      load_err_d   = load_err_q;
      byte_count_d = byte_count_q;
      hold_load    = 1'b0;
      hold_en      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (dl_match) begin
               state_d      = StLoad;
               cpu_reset_d  = 1'b1;
               byte_count_d = '0;
               load_err_d   = 1'b0;
               rom_loaded_d = 1'b0;
            end else if (reset_req_i) begin
               state_d     = StHold;
               cpu_reset_d = 1'b1;
               hold_load   = 1'b1;
            end
         end
         StLoad: begin
            if (ioctl_wr_i && in_range) begin
               // A falling download in the same cycle is honoured after this write.
               rom_addr_d   = ioctl_addr_i[ROM_AW-1:0];
               rom_data_d   = ioctl_dout_i;
               rom_req_d    = 1'b1;
               ioctl_wait_d = 1'b1;
               state_d      = StWrite;
            end else begin
               if (ioctl_wr_i) begin
                  load_err_d = 1'b1;
               end
               if (!ioctl_download_i) begin
                  state_d      = StHold;
                  hold_load    = 1'b1;
                  rom_loaded_d = (byte_count_d != '0) && !load_err_d;
               end
            end
         end
         StWrite: begin
            if (ioctl_wr_i) begin
               load_err_d = 1'b1;
            end
            if (rom_ack_i) begin
               rom_req_d    = 1'b0;
               ioctl_wait_d = 1'b0;
               byte_count_d = (byte_count_q == COUNT_MAX) ? byte_count_q
                                                          : byte_count_q + COUNT_ONE;
               if (ioctl_download_i) begin
                  state_d = StLoad;
               end else begin
                  state_d      = StHold;
                  hold_load    = 1'b1;
                  rom_loaded_d = (byte_count_d != '0) && !load_err_d;
               end
            end
         end
         StHold: begin
            if (dl_match) begin
               state_d      = StLoad;
               byte_count_d = '0;
               load_err_d   = 1'b0;
               rom_loaded_d = 1'b0;
            end else if (reset_req_i) begin
               hold_load = 1'b1;
            end else begin
               hold_en = hold_busy;
               if (hold_last || !hold_busy) begin
                  cpu_reset_d = 1'b0;
                  state_d     = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StHold;
         cpu_reset_q  <= 1'b1;
         ioctl_wait_q <= 1'b0;
         rom_req_q    <= 1'b0;
         rom_addr_q   <= '0;
         rom_data_q   <= '0;
         rom_loaded_q <= 1'b0;
         load_err_q   <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cpu_reset_q  <= cpu_reset_d;
         ioctl_wait_q <= ioctl_wait_d;
         rom_req_q    <= rom_req_d;
         rom_addr_q   <= rom_addr_d;
         rom_data_q   <= rom_data_d;
         rom_loaded_q <= rom_loaded_d;
         load_err_q   <= load_err_d;
         byte_count_q <= byte_count_d;
      end
   end

   assign cpu_reset_o  = cpu_reset_q;
   assign ioctl_wait_o = ioctl_wait_q;
   assign rom_req_o    = rom_req_q;
   assign rom_addr_o   = rom_addr_q;
   assign rom_data_o   = rom_data_q;
   assign rom_loaded_o = rom_loaded_q;
   assign load_err_o   = load_err_q;
   assign byte_count_o = byte_count_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: table-driven loads, hand-built corner sequences and random
// downloads checked against a transaction-level model of the loader.
module tb_rom_load_ctrl;

   localparam int unsigned RST = 1024;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        rom_ack = 1'b0;
   logic        reset_req = 1'b0;
   logic        ioctl_wait, rom_req, cpu_reset, rom_loaded, load_err;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;
   logic [15:0] byte_count;

   rom_load_ctrl #(
      .ROM_AW     (15),
      .LOAD_INDEX (8'd1),
      .RST_CYCLES (RST)
   ) dut (
      .clk_sys_i        (clk_sys),
      .reset_i          (reset),
      .ioctl_download_i (ioctl_download),
      .ioctl_index_i    (ioctl_index),
      .ioctl_wr_i       (ioctl_wr),
      .ioctl_addr_i     (ioctl_addr),
      .ioctl_dout_i     (ioctl_dout),
      .ioctl_wait_o     (ioctl_wait),
      .rom_req_o        (rom_req),
      .rom_addr_o       (rom_addr),
      .rom_data_o       (rom_data),
      .rom_ack_i        (rom_ack),
      .reset_req_i      (reset_req),
      .cpu_reset_o      (cpu_reset),
      .rom_loaded_o     (rom_loaded),
      .load_err_o       (load_err),
      .byte_count_o     (byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned n_writes = 0;
   logic        exp_pend = 1'b0;
   logic [14:0] exp_addr = '0;
   logic [7:0]  exp_data = '0;
   int unsigned exp_len = 0;
   int unsigned cur_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write-port monitor: a write is expected exactly while exp_pend is set.
   always @(negedge clk_sys) begin
      if (!reset && (rom_req || ioctl_wait || exp_pend)) begin
         check("rom_req", 32'(rom_req), 32'(exp_pend));
         check("ioctl_wait", 32'(ioctl_wait), 32'(exp_pend));
         if (exp_pend) begin
            check("rom_addr", 32'(rom_addr), 32'(exp_addr));
            check("rom_data", 32'(rom_data), 32'(exp_data));
            cur_len++;
            if (rom_ack) begin
               check("req_len", cur_len, exp_len);
               exp_pend = 1'b0;
               cur_len  = 0;
            end
         end
      end
      if (rom_req && rom_ack) n_writes++;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      tick();
   endtask

   task automatic wait_release();
      int unsigned n = 0;
      while (cpu_reset && n < 5000) begin
         tick();
         n++;
      end
      check("hold_len", n, RST);
   endtask

   task automatic send(input logic [24:0] addr, input logic [7:0] data,
                       input int unsigned delay, input logic exp_wr);
      int unsigned cnt = 0;
      ioctl_addr = addr;
      ioctl_dout = data;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      if (exp_wr) begin
         exp_addr = addr[14:0];
         exp_data = data;
         exp_len  = delay + 1;
         cur_len  = 0;
         exp_pend = 1'b1;
         while (ioctl_wait && cnt < 100) begin
            rom_ack = (cnt >= delay);
            tick();
            cnt++;
         end
         rom_ack = 1'b0;
         check("wait_bound", 32'(ioctl_wait), 32'd0);
         exp_pend = 1'b0;
      end
   endtask

   typedef struct {
      int unsigned grp;
      logic [24:0] addr;
      logic [7:0]  data;
      int unsigned delay;
      logic        exp_wr;
   } vec_t;

   typedef struct {
      int unsigned count;
      logic        err;
      logic        loaded;
   } res_t;

   vec_t        vecs[9];
   res_t        res[3];
   int unsigned w0, cnt, nb;
   logic        err, oor, idle, model_loaded;
   logic [7:0]  idx;
   logic [24:0] a;

   initial begin
      vecs[0] = '{0, 25'h0000, 8'hA5, 0, 1'b1};
      vecs[1] = '{0, 25'h0001, 8'h5A, 0, 1'b1};
      vecs[2] = '{0, 25'h0002, 8'h00, 0, 1'b1};
      vecs[3] = '{0, 25'h0003, 8'hFF, 0, 1'b1};
      vecs[4] = '{1, 25'h0100, 8'hC3, 5, 1'b1};
      vecs[5] = '{1, 25'h7FFF, 8'h3C, 5, 1'b1};
      vecs[6] = '{2, 25'h0010, 8'h11, 1, 1'b1};
      vecs[7] = '{2, 25'h8000, 8'h22, 0, 1'b0};
      vecs[8] = '{2, 25'h0011, 8'h33, 2, 1'b1};
      res[0]  = '{4, 1'b0, 1'b1};
      res[1]  = '{2, 1'b0, 1'b1};
      res[2]  = '{2, 1'b1, 1'b0};

      // Power-up
      repeat (3) tick();
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_req", 32'(rom_req), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      check("rst_data", 32'(rom_data), 32'd0);
      check("rst_loaded", 32'(rom_loaded), 32'd0);
      check("rst_err", 32'(load_err), 32'd0);
      check("rst_count", 32'(byte_count), 32'd0);
      reset = 1'b0;
      wait_release();
      check("pwr_loaded", 32'(rom_loaded), 32'd0);

      // Table-driven loads
      for (int g = 0; g < 3; g++) begin
         w0 = n_writes;
         start_dl(8'd1);
         check("load_cpu_reset", 32'(cpu_reset), 32'd1);
         for (int i = 0; i < 9; i++) begin
            if (vecs[i].grp == g)
               send(vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].exp_wr);
         end
         end_dl();
         check("tbl_count", 32'(byte_count), res[g].count);
         check("tbl_err", 32'(load_err), 32'(res[g].err));
         check("tbl_loaded", 32'(rom_loaded), 32'(res[g].loaded));
         check("tbl_writes", n_writes - w0, res[g].count);
         wait_release();
         check("tbl_loaded_idle", 32'(rom_loaded), 32'(res[g].loaded));
      end

      // Byte strobe together with download falling
      start_dl(8'd1);
      ioctl_addr = 25'h7; ioctl_dout = 8'h3C; ioctl_wr = 1'b1; ioctl_download = 1'b0;
      tick();
      ioctl_wr = 1'b0;
      exp_addr = 15'h7; exp_data = 8'h3C; exp_len = 1; cur_len = 0; exp_pend = 1'b1;
      rom_ack = 1'b1;
      tick();
      rom_ack = 1'b0;
      check("fall_count", 32'(byte_count), 32'd1);
      check("fall_err", 32'(load_err), 32'd0);
      check("fall_loaded", 32'(rom_loaded), 32'd1);
      check("fall_cpu_reset", 32'(cpu_reset), 32'd1);
      wait_release();

      // Foreign index is ignored
      w0 = n_writes;
      start_dl(8'd2);
      check("idx2_cpu_reset", 32'(cpu_reset), 32'd0);
      send(25'h3, 8'h44, 0, 1'b0);
      end_dl();
      check("idx2_cpu_reset_end", 32'(cpu_reset), 32'd0);
      check("idx2_loaded", 32'(rom_loaded), 32'd1);
      check("idx2_count", 32'(byte_count), 32'd1);
      check("idx2_writes", n_writes - w0, 32'd0);

      // Overrun: second strobe while the first write is pending
      start_dl(8'd1);
      ioctl_addr = 25'h5; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
      tick();
      exp_addr = 15'h5; exp_data = 8'h77; exp_len = 3; cur_len = 0; exp_pend = 1'b1;
      ioctl_addr = 25'h6; ioctl_dout = 8'h88;
      tick();
      ioctl_wr = 1'b0;
      tick();
      rom_ack = 1'b1;
      tick();
      rom_ack = 1'b0;
      check("ovr_err", 32'(load_err), 32'd1);
      check("ovr_count", 32'(byte_count), 32'd1);
      end_dl();
      check("ovr_loaded", 32'(rom_loaded), 32'd0);
      wait_release();

      // reset_req from IDLE, then again mid-HOLD
      reset_req = 1'b1;
      tick();
      reset_req = 1'b0;
      check("rreq_cpu_reset", 32'(cpu_reset), 32'd1);
      repeat (100) tick();
      reset_req = 1'b1;
      tick();
      reset_req = 1'b0;
      wait_release();
      check("rreq_loaded", 32'(rom_loaded), 32'd0);

      // reset_req and download start together: the download wins
      w0 = n_writes;
      reset_req = 1'b1;
      start_dl(8'd1);
      reset_req = 1'b0;
      check("both_cpu_reset", 32'(cpu_reset), 32'd1);
      send(25'h42, 8'h9C, 1, 1'b1);
      end_dl();
      check("both_writes", n_writes - w0, 32'd1);
      check("both_loaded", 32'(rom_loaded), 32'd1);
      wait_release();

      // Async reset in the middle of a write
      start_dl(8'd1);
      ioctl_addr = 25'h20; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      exp_addr = 15'h20; exp_data = 8'h99; exp_len = 10; cur_len = 0; exp_pend = 1'b1;
      repeat (2) tick();
      #2;
      reset = 1'b1;
      exp_pend = 1'b0;
      cur_len  = 0;
      #1;
      check("arst_req", 32'(rom_req), 32'd0);
      check("arst_wait", 32'(ioctl_wait), 32'd0);
      check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("arst_loaded", 32'(rom_loaded), 32'd0);
      ioctl_download = 1'b0;
      tick();
      reset = 1'b0;
      wait_release();

      // Random downloads against the transaction model
      idle = 1'b1;
      model_loaded = 1'b0;
      for (int it = 0; it < 12; it++) begin
         idx = (idle && $urandom_range(0, 3) == 0) ? 8'd2 : 8'd1;
         w0 = n_writes; cnt = 0; err = 1'b0;
         start_dl(idx);
         nb = $urandom_range(1, 6);
         for (int b = 0; b < int'(nb); b++) begin
            oor = ($urandom_range(0, 5) == 0);
            a = oor ? 25'h8000 + 25'($urandom_range(0, 4095)) : 25'($urandom_range(0, 32767));
            if (idx == 8'd1) begin
               if (oor) err = 1'b1;
               else cnt++;
            end
            send(a, 8'($urandom), $urandom_range(0, 3), (idx == 8'd1) && !oor);
         end
         end_dl();
         check("rnd_writes", n_writes - w0, cnt);
         if (idx == 8'd1) begin
            model_loaded = (cnt != 0) && !err;
            check("rnd_count", 32'(byte_count), cnt);
            check("rnd_err", 32'(load_err), 32'(err));
            check("rnd_loaded", 32'(rom_loaded), 32'(model_loaded));
            if ($urandom_range(0, 1) == 1) begin
               wait_release();
               idle = 1'b1;
            end else begin
               idle = 1'b0;
            end
         end else begin
            check("rnd_idx2_cpu_reset", 32'(cpu_reset), 32'd0);
            check("rnd_idx2_loaded", 32'(rom_loaded), 32'(model_loaded));
         end
      end
      if (!idle) wait_release();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
